// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle between host bus adapters, the command arbiter and the SDRAM sequencer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sdram_cmd_arbiter_if #(
  parameter int NUM_CH  = 2,
  parameter int PADDR_W = 24,
  parameter int CMD_W   = 3
);
  logic [NUM_CH*CMD_W-1:0]   ch_cmd;
  logic [NUM_CH*PADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]         ch_cmdack;
  logic                      cmack;
  logic                      ref_ack;
  logic [PADDR_W-1:0]        caddr;
  logic [2:0]                grant_ch;
  logic                      nop;
  logic                      reada;
  logic                      writea;
  logic                      refresh;
  logic                      precharge;
  logic                      load_mod;
  logic [1:0]                cas_lat;
  logic [1:0]                ras_cas;
  logic [3:0]                ref_dur;
  logic                      page_mod;
  logic [2:0]                bur_len;
  logic                      ref_req;
  logic [3:0]                ref_pend;
  logic                      ref_ovf;

  modport slave (
    input  ch_cmd, ch_addr, cmack, ref_ack,
    output ch_cmdack, caddr, grant_ch, nop, reada, writea, refresh, precharge, load_mod,
    output cas_lat, ras_cas, ref_dur, page_mod, bur_len, ref_req, ref_pend, ref_ovf
  );

  modport master (
    output ch_cmd, ch_addr, cmack, ref_ack,
    input  ch_cmdack, caddr, grant_ch, nop, reada, writea, refresh, precharge, load_mod,
    input  cas_lat, ras_cas, ref_dur, page_mod, bur_len, ref_req, ref_pend, ref_ovf
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Round-robin SDRAM command arbiter with timing/mode registers and a queued refresh timer.
// Define REF_PRIORITY_EN to stall new grants while the refresh queue is full.
module sdram_cmd_arbiter #(
  parameter int NUM_CH       = 2,
  parameter int PADDR_W      = 24,
  parameter int CMD_W        = 3,
  parameter int REF_CNT_W    = 16,
  parameter int MAX_PEND_REF = 4
) (
  input logic              clk0,
  input logic              reset,
  sdram_cmd_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] LOCAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CMD_W-1:0] CMD_READA      = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WRITEA     = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_REFRESH    = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_PRECHARGE  = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_LOAD_MODE  = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_LOAD_TIME  = CMD_W'(6);
  localparam logic [3:0]       PEND_MAX       = 4'(MAX_PEND_REF);

  logic [1:0]           state_q, state_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [PADDR_W-1:0]   caddr_q, caddr_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           rrPtr_q, rrPtr_d;
  logic [1:0]           casLat_q, casLat_d;
  logic [1:0]           rasCas_q, rasCas_d;
  logic [3:0]           refDur_q, refDur_d;
  logic                 pageMod_q, pageMod_d;
  logic [2:0]           burLen_q, burLen_d;
  logic [REF_CNT_W-1:0] rfCnt_q, rfCnt_d;
  logic [REF_CNT_W-1:0] timer_q, timer_d;
  logic [3:0]           refPend_q, refPend_d;
  logic                 refOvf_q, refOvf_d;

  logic                 hit;
  logic [2:0]           pick;
  logic [2:0]           cand;
  logic [CMD_W-1:0]     selCmd;
  logic [PADDR_W-1:0]   selAddr;
  logic                 grantBlock;
  logic                 loadRf;
  logic                 tick;
  logic                 ackEff;
  logic                 nopS, readaS, writeaS, refreshS, prechargeS, loadModS;

`ifdef REF_PRIORITY_EN
  assign grantBlock = (refPend_q == PEND_MAX);
`else
  assign grantBlock = 1'b0;
`endif

  // Scan starts one past the last winner so every channel gets a turn.
  always_comb begin
    hit  = 1'b0;
    pick = rrPtr_q;
    cand = rrPtr_q;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = 3'((int'(rrPtr_q) + k) % NUM_CH);
      if (!hit && bus.ch_cmd[cand*CMD_W +: CMD_W] != '0) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  assign selCmd  = bus.ch_cmd[pick*CMD_W +: CMD_W];
  assign selAddr = bus.ch_addr[pick*PADDR_W +: PADDR_W];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    caddr_d   = caddr_q;
    grant_d   = grant_q;
    rrPtr_d   = rrPtr_q;
    casLat_d  = casLat_q;
    rasCas_d  = rasCas_q;
    refDur_d  = refDur_q;
    pageMod_d = pageMod_q;
    burLen_d  = burLen_q;
    rfCnt_d   = rfCnt_q;
    loadRf    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit && !grantBlock) begin
          cmd_d   = selCmd;
          caddr_d = selAddr;
          grant_d = pick;
          rrPtr_d = pick;
          state_d = (selCmd >= CMD_LOAD_TIME) ? LOCAL : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cmack) state_d = DONE;
      end
      LOCAL: begin
        if (cmd_q == CMD_LOAD_TIME) begin
          casLat_d  = caddr_q[1:0];
          rasCas_d  = caddr_q[3:2];
          refDur_d  = caddr_q[7:4];
          pageMod_d = caddr_q[8];
          burLen_d  = caddr_q[11:9];
        end else begin
          rfCnt_d = caddr_q[REF_CNT_W-1:0];
          loadRf  = 1'b1;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Period equals refresh_count: the tick fires as the count would hit zero.
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (loadRf) begin
      timer_d = caddr_q[REF_CNT_W-1:0];
    end else if (rfCnt_q != '0) begin
      if (timer_q <= REF_CNT_W'(1)) begin
        tick    = 1'b1;
        timer_d = rfCnt_q;
      end else begin
        timer_d = timer_q - REF_CNT_W'(1);
      end
    end
  end

  always_comb begin
    ackEff    = bus.ref_ack && (refPend_q != 4'd0);
    refPend_d = refPend_q;
    refOvf_d  = refOvf_q;
    if (tick && !ackEff) begin
      if (refPend_q == PEND_MAX) refOvf_d = 1'b1;
      else                       refPend_d = refPend_q + 4'd1;
    end else if (!tick && ackEff) begin
      refPend_d = refPend_q - 4'd1;
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      caddr_q   <= '0;
      grant_q   <= 3'd0;
      rrPtr_q   <= 3'(NUM_CH - 1);
      casLat_q  <= 2'd2;
      rasCas_q  <= 2'd2;
      refDur_q  <= 4'd7;
      pageMod_q <= 1'b0;
      burLen_q  <= 3'd0;
      rfCnt_q   <= '0;
      timer_q   <= '0;
      refPend_q <= 4'd0;
      refOvf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      caddr_q   <= caddr_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      casLat_q  <= casLat_d;
      rasCas_q  <= rasCas_d;
      refDur_q  <= refDur_d;
      pageMod_q <= pageMod_d;
      burLen_q  <= burLen_d;
      rfCnt_q   <= rfCnt_d;
      timer_q   <= timer_d;
      refPend_q <= refPend_d;
      refOvf_q  <= refOvf_d;
    end
  end

  always_comb begin
    nopS       = 1'b0;
    readaS     = 1'b0;
    writeaS    = 1'b0;
    refreshS   = 1'b0;
    prechargeS = 1'b0;
    loadModS   = 1'b0;
    if (state_q == ISSUE) begin
      case (cmd_q)
        CMD_READA:     readaS     = 1'b1;
        CMD_WRITEA:    writeaS    = 1'b1;
        CMD_REFRESH:   refreshS   = 1'b1;
        CMD_PRECHARGE: prechargeS = 1'b1;
        CMD_LOAD_MODE: loadModS   = 1'b1;
        default:       nopS       = 1'b1;
      endcase
    end
  end

  assign bus.nop       = nopS;
  assign bus.reada     = readaS;
  assign bus.writea    = writeaS;
  assign bus.refresh   = refreshS;
  assign bus.precharge = prechargeS;
  assign bus.load_mod  = loadModS;
  assign bus.ch_cmdack = (state_q == DONE) ? (NUM_CH'(1) << grant_q) : '0;
  assign bus.caddr     = caddr_q;
  assign bus.grant_ch  = grant_q;
  assign bus.cas_lat   = casLat_q;
  assign bus.ras_cas   = rasCas_q;
  assign bus.ref_dur   = refDur_q;
  assign bus.page_mod  = pageMod_q;
  assign bus.bur_len   = burLen_q;
  assign bus.ref_req   = (refPend_q != 4'd0);
  assign bus.ref_pend  = refPend_q;
  assign bus.ref_ovf   = refOvf_q;
endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Multi-channel successor to the single-host SDRAM controller command interface.
- Accepts commands from NUM_CH requesters and round-robin arbitrates them into one command/address stream for the SDRAM sequencer.
- Owns the timing/mode configuration registers and a refresh timer that queues postponed refreshes.
- Sits between the host-side bus adapters and the SDRAM sequencer.

Parameters:
- NUM_CH, 2: number of requester channels (1..8).
- PADDR_W, 24: address width per channel; must be >= 16.
- CMD_W, 3: command code width.
- REF_CNT_W, 16: refresh interval counter width.
- MAX_PEND_REF, 4: maximum queued refresh requests (1..15).

Ports:
- clk0  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ch_cmd  in  NUM_CH*CMD_W  per-channel command code; channel i occupies bits [i*CMD_W +: CMD_W].
- ch_addr  in  NUM_CH*PADDR_W  per-channel address/data, packed the same way.
- ch_cmdack  out  NUM_CH  per-channel one-cycle acknowledge.
- cmack  in  1  sequencer has accepted the current SDRAM command.
- ref_ack  in  1  sequencer has completed one refresh.
- caddr  out  PADDR_W  address of the granted command.
- grant_ch  out  3  index of the granted channel.
- nop, reada, writea, refresh, precharge, load_mod  out  1 each  command strobes.
- cas_lat  out  2  CAS latency register.
- ras_cas  out  2  RAS-to-CAS delay register.
- ref_dur  out  4  refresh duration register.
- page_mod  out  1  page mode register.
- bur_len  out  3  burst length register.
- ref_req  out  1  at least one refresh is pending.
- ref_pend  out  4  number of pending refreshes.
- ref_ovf  out  1  sticky flag: a refresh tick was lost because the queue was full.

Behaviour:
- Command codes:
  - 0 NOP/idle (never granted).
  - 1 READA, 2 WRITEA, 3 REFRESH, 4 PRECHARGE, 5 LOAD_MODE.
  - 6 LOAD_TIME, 7 LOAD_RFCNT.
- Reset values:
  - All strobes, ch_cmdack, caddr, grant_ch = 0.
  - cas_lat=2, ras_cas=2, ref_dur=7, page_mod=0, bur_len=0.
  - refresh_count=0, which disables the timer.
  - ref_pend=0, ref_ovf=0.
  - FSM=IDLE; rr_ptr=NUM_CH-1, so channel 0 wins first.
- FSM IDLE:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo NUM_CH for the first nonzero ch_cmd.
  - On a hit, register cmd, caddr and grant_ch, set rr_ptr to the granted channel, and go to ISSUE (codes 1-5) or LOCAL (codes 6-7).
- FSM ISSUE:
  - The matching one-hot strobe is held high until cmack=1 is sampled.
  - Then clear the strobe and go to DONE.
  - If cmack=1 on the first ISSUE cycle, ISSUE lasts exactly one cycle.
- FSM LOCAL:
  - LOAD_TIME: cas_lat=caddr[1:0], ras_cas=caddr[3:2], ref_dur=caddr[7:4], page_mod=caddr[8], bur_len=caddr[11:9].
  - LOAD_RFCNT: refresh_count=caddr[REF_CNT_W-1:0]; the timer reloads immediately.
  - Next state: DONE. No strobe is asserted.
- FSM DONE:
  - ch_cmdack[grant_ch]=1 for exactly one cycle, then go to IDLE.
  - Requesters hold ch_cmd stable until they see the ack and drop it on the following edge, so IDLE never re-grants a stale command.
- Latency:
  - Grant to strobe: 1 cycle after the request is sampled in IDLE.
  - Local register load to ack: 2 cycles.
- Refresh timer:
  - While refresh_count != 0, a down-counter reloads with refresh_count on reaching 0 and produces a tick.
  - On a tick: ref_pend increments, saturating at MAX_PEND_REF. A tick arriving at saturation sets ref_ovf, which is cleared only by reset.
  - ref_ack decrements ref_pend; ref_ack while ref_pend=0 is ignored.
  - Tick and ref_ack in the same cycle leave ref_pend unchanged.
  - ref_req = (ref_pend != 0).
- A synchronous reset mid-transaction aborts it: return to IDLE, clear strobes, no ack is issued.
- Configuration registers written by LOAD_TIME are visible on the cycle after LOCAL.

Optional Feature:
- Macro REF_PRIORITY_EN.
- Defined: while ref_pend == MAX_PEND_REF, IDLE issues no new grants; a transaction already in progress completes normally.
- Undefined: arbitration ignores refresh state.

Test Plan:
- Reset, then ch0 cmd=1 with addr=0x000123, cmack tied high → reada=1 and caddr=0x000123 one cycle later; ch_cmdack=2'b01 in the following cycle.
- ch0 and ch1 both request cmd=2 continuously, each re-requesting after its ack → grants alternate 0,1,0,1; each writea pulse is held until cmack.
- ch1 cmd=6 with addr=0x0A5B → cas_lat=3, ras_cas=2, ref_dur=5, page_mod=0, bur_len=5; no strobe asserted; ack 2 cycles after grant.
- LOAD_RFCNT with value 10, no ref_ack, MAX_PEND_REF=4 → ref_req rises after about 10 cycles; ref_pend reaches 4; ref_ovf=1 after the 5th tick; one ref_ack pulse gives ref_pend=3.
- Tick coinciding with ref_ack at ref_pend=2 → ref_pend stays 2.
- Reset asserted while in ISSUE with reada high → next cycle reada=0, no ack, all registers back to reset values. With REF_PRIORITY_EN defined and ref_pend saturated, a new request is not granted until ref_ack.
